// File: rtl/p2s_master_mch.sv
// ---------------------------------------------------------------------------
// p2s_master_mch
// Multi-channel parallel-to-serial master. NCH serial lines share one
// sclk/sld_n pair. Bit timing is paced by an external, asynchronous tick:
// every rising tick edge advances one half sclk period. A frame carries NBIT
// data bits per channel, LSB first, optionally followed by an even-parity
// bit (PAR=1). Return data on si is captured in the same frame and presented
// as parallel words with a one-cycle po_vld pulse and a per-channel parity
// check.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   tick            bit-phase pacing strobe (asynchronous)
//   mode            1 = continuous while en=1, 0 = one-shot via start
//   en              continuous-mode enable
//   start           one-shot request pulse
//   pi              parallel transmit data, channel c = pi[c*NBIT +: NBIT]
//   si              serial return data (asynchronous)
//   so              serial transmit data
//   sclk, sld_n     shared serial clock and active-low frame sync
//   busy            request pending or frame running
//   frame_done      one-cycle pulse at the end of every frame
//   po, po_vld      captured return data and its update strobe
//   perr            per-channel parity error of the last frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module p2s_master_mch #(
  parameter int NBIT = 64,
  parameter int NCH  = 2,
  parameter int PAR  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                mode,
  input  logic                en,
  input  logic                start,
  input  logic [NCH*NBIT-1:0] pi,
  input  logic [NCH-1:0]      si,
  output logic [NCH-1:0]      so,
  output logic                sclk,
  output logic                sld_n,
  output logic                busy,
  output logic                frame_done,
  output logic [NCH*NBIT-1:0] po,
  output logic                po_vld,
  output logic [NCH-1:0]      perr
);

  localparam int FLEN = NBIT + PAR;
  localparam int WCNT = ($clog2(2 * FLEN) < 1) ? 1 : $clog2(2 * FLEN);
  localparam logic [WCNT-1:0] CNT_LAST = WCNT'(2 * FLEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q;
  logic [WCNT-1:0]       cnt_q;
  logic                  req_q;
  logic [2:0]            tick_q;
  logic [NCH-1:0]        si_s1_q;
  logic [NCH-1:0]        si_s2_q;
  logic [NCH*NBIT-1:0]   shadow_q;
  logic [FLEN-1:0]       cap_q [NCH];
  logic [FLEN-1:0]       cap_d [NCH];
  logic                  frame_done_q;
  logic                  po_vld_q;
  logic [NCH*NBIT-1:0]   po_q;
  logic [NCH-1:0]        perr_q;

  logic                  tick_pp;
  logic [WCNT-1:0]       bidx;
  logic [NCH-1:0]        so_dec;

  // Rising edge of the synchronised tick; only these cycles advance state.
  assign tick_pp = (tick_q[2:1] == 2'b01);
  // Two counter steps per bit: even = sclk low (launch), odd = sclk high.
  assign bidx    = cnt_q >> 1;

  always_comb begin : so_decode
    so_dec = '0;
    if (state_q == RUN) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NBIT; i++) begin
          if (bidx == WCNT'(i)) so_dec[c] = shadow_q[c*NBIT + i];
        end
        if ((PAR != 0) && (bidx == WCNT'(NBIT))) so_dec[c] = ^shadow_q[c*NBIT +: NBIT];
      end
    end
  end

  // Capture image including the bit sampled on the current edge, so that the
  // frame-end update of po sees the final bit without an extra cycle.
  always_comb begin : cap_next
    cap_d = cap_q;
    if ((state_q == RUN) && tick_pp && cnt_q[0]) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < FLEN; i++) begin
          if (bidx == WCNT'(i)) cap_d[c][i] = si_s2_q[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      tick_q       <= '0;
      si_s1_q      <= '0;
      si_s2_q      <= '0;
      shadow_q     <= '0;
      for (int c = 0; c < NCH; c++) cap_q[c] <= '0;
      frame_done_q <= 1'b0;
      po_vld_q     <= 1'b0;
      po_q         <= '0;
      perr_q       <= '0;
    end else begin
      tick_q       <= {tick_q[1:0], tick};
      si_s1_q      <= si;
      si_s2_q      <= si_s1_q;
      cap_q        <= cap_d;
      frame_done_q <= 1'b0;
      po_vld_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_pp && ((mode && en) || req_q)) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            shadow_q <= pi;
            req_q    <= 1'b0;
          end else if (!mode && start && !req_q) begin
            req_q <= 1'b1;
          end
        end
        RUN: begin
          if (tick_pp) begin
            if (cnt_q == CNT_LAST) begin
              frame_done_q <= 1'b1;
              po_vld_q     <= 1'b1;
              for (int c = 0; c < NCH; c++) begin
                po_q[c*NBIT +: NBIT] <= cap_d[c][NBIT-1:0];
                perr_q[c] <= (PAR != 0) && ((^cap_d[c][NBIT-1:0]) != cap_d[c][FLEN-1]);
              end
              cnt_q <= '0;
              // Back-to-back restart: no idle tick between frames.
              if (mode && en) shadow_q <= pi;
              else            state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign so         = so_dec;
  assign sclk       = (state_q == RUN) && cnt_q[0];
  assign sld_n      = !((state_q == RUN) && (bidx == '0));
  assign busy       = req_q || (state_q == RUN);
  assign frame_done = frame_done_q;
  assign po         = po_q;
  assign po_vld     = po_vld_q;
  assign perr       = perr_q;

endmodule

// File: tb/tb_p2s_master_mch.sv
// ---------------------------------------------------------------------------
// tb_p2s_master_mch
// Two instances (NBIT=8, NCH=2), PAR=0 and PAR=1, share clk, rst_n, tick and
// pi; each has its own mode/en/start and si. A per-instance monitor watches
// the serial side at frame level: it latches the transmitted word at sld_n
// fall, checks each bit presented at sclk rise, drives si (loopback with an
// optional bit-flip mask, or a fixed return word) and checks po/perr at
// frame_done against words computed from that plan.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_p2s_master_mch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tick;
  logic [1:0]  mode_v, en_v, start_v;
  logic [15:0] pi;

  logic [1:0]  so_w   [2];
  logic [1:0]  sclk_w, sld_w, busy_w, fd_w, vld_w;
  logic [15:0] po_w   [2];
  logic [1:0]  perr_w [2];

  // Return-data plan per instance / channel.
  logic        loop_cfg  [2][2];
  logic [8:0]  flip_cfg  [2][2];
  logic [8:0]  dword_cfg [2][2];

  int          fdone  [2];
  int          fstart [2];
  logic [15:0] pi_log [2][16];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] frame_word(input logic [7:0] d);
    return {^d, d};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int F = 8 + g;
    logic [1:0]  si_l;
    logic        in_frame, psclk, psld, b;
    int          rises, cur;
    logic [15:0] fpi;
    logic [8:0]  dw [2];
    logic [8:0]  ew;

    p2s_master_mch #(.NBIT(8), .NCH(2), .PAR(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode_v[g]), .en(en_v[g]),
      .start(start_v[g]), .pi(pi), .si(si_l), .so(so_w[g]), .sclk(sclk_w[g]),
      .sld_n(sld_w[g]), .busy(busy_w[g]), .frame_done(fd_w[g]), .po(po_w[g]),
      .po_vld(vld_w[g]), .perr(perr_w[g])
    );

    initial begin
      in_frame = 0; psclk = 0; psld = 1; rises = 0; cur = 0; fpi = '0;
      dw[0] = '0; dw[1] = '0; si_l = '0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          in_frame = 0; psclk = 0; psld = 1; cur = 0; si_l = '0;
        end else begin
          if (fd_w[g]) begin
            fdone[g]++;
            chk($sformatf("po_vld%0d", g), vld_w[g], 1);
            chk($sformatf("fd_in_frame%0d", g), in_frame, 1);
            if (in_frame) begin
              chk($sformatf("nbits%0d", g), rises, F);
              for (int c = 0; c < 2; c++) begin
                ew = loop_cfg[g][c] ? frame_word(fpi[c*8 +: 8]) : dw[c];
                ew = ew ^ flip_cfg[g][c];
                chk($sformatf("po%0d_ch%0d", g, c), po_w[g][c*8 +: 8], ew[7:0]);
                chk($sformatf("perr%0d_ch%0d", g, c), perr_w[g][c],
                    (g == 1) ? ((^ew[7:0]) ^ ew[8]) : 1'b0);
              end
              in_frame = 0;
            end
          end else if (vld_w[g]) begin
            chk($sformatf("vld_without_fd%0d", g), fd_w[g], 1);
          end
          if (psld && !sld_w[g]) begin
            in_frame = 1; rises = 0; cur = 0; fpi = pi;
            fstart[g]++;
            pi_log[g][fstart[g] % 16] = pi;
            dw[0] = dword_cfg[g][0];
            dw[1] = dword_cfg[g][1];
          end
          if (!psclk && sclk_w[g]) begin
            chk($sformatf("sclk_in_frame%0d", g), in_frame, 1);
            if (in_frame) begin
              for (int c = 0; c < 2; c++) begin
                b = (rises < 8) ? fpi[c*8 + rises] : ^fpi[c*8 +: 8];
                chk($sformatf("so%0d_ch%0d_b%0d", g, c, rises), so_w[g][c], b);
              end
              chk($sformatf("sld_n%0d_b%0d", g, rises), sld_w[g], rises != 0);
              cur = (rises < F) ? rises : F - 1;
              rises++;
            end
          end
          for (int c = 0; c < 2; c++)
            si_l[c] = loop_cfg[g][c] ? (so_w[g][c] ^ flip_cfg[g][c][cur]) : dw[c][cur];
          psclk = sclk_w[g];
          psld  = sld_w[g];
        end
      end
    end
  end

  // All drive tasks start and end 2 ns after a rising clk edge.
  task automatic ticks(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      repeat (h) @(posedge clk);
      #2 tick = 1'b0;
      repeat (l) @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    @(posedge clk);
    #2 start_v[g] = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_so%0d", tag, g), so_w[g], 0);
      chk($sformatf("%s_sclk%0d", tag, g), sclk_w[g], 0);
      chk($sformatf("%s_sld_n%0d", tag, g), sld_w[g], 1);
      chk($sformatf("%s_busy%0d", tag, g), busy_w[g], 0);
      chk($sformatf("%s_fd%0d", tag, g), fd_w[g], 0);
      chk($sformatf("%s_po%0d", tag, g), po_w[g], 0);
      chk($sformatf("%s_vld%0d", tag, g), vld_w[g], 0);
      chk($sformatf("%s_perr%0d", tag, g), perr_w[g], 0);
    end
  endtask

  task automatic oneshot(input int g, input int h, input int l);
    int base;
    base = fdone[g];
    pulse_start(g);
    chk($sformatf("os_busy_rise%0d", g), busy_w[g], 1);
    ticks(2 * (8 + g) + 1, h, l);
    chk($sformatf("os_frames%0d", g), fdone[g] - base, 1);
    chk($sformatf("os_busy_fall%0d", g), busy_w[g], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int base, bst, h, l, g;
    logic [15:0] pa, pb;
    rst_n = 1'b0; tick = 1'b0; mode_v = '0; en_v = '0; start_v = '0; pi = '0;
    for (int i = 0; i < 2; i++) begin
      fdone[i] = 0; fstart[i] = 0;
      for (int c = 0; c < 2; c++) begin
        loop_cfg[i][c] = 1'b1; flip_cfg[i][c] = '0; dword_cfg[i][c] = '0;
      end
    end

    // Reset state, then no activity without a request.
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    #1 rst_n = 1'b1;
    ticks(5, 2, 3);
    chk("idle_frames0", fdone[0], 0);
    chk("idle_frames1", fdone[1], 0);
    chk("idle_busy0", busy_w[0], 0);

    // Directed one-shot: ch0 looped back, ch1 returns all ones.
    pi = 16'hA53C;
    loop_cfg[0][0] = 1'b1; loop_cfg[0][1] = 1'b0; dword_cfg[0][1] = 9'h1FF;
    oneshot(0, 2, 2);
    chk("os_po_direct", po_w[0], 16'hFF3C);

    // Randomised one-shot frames on both instances.
    for (int r = 0; r < 6; r++) begin
      g = r % 2;
      pi = 16'($urandom);
      for (int c = 0; c < 2; c++) begin
        loop_cfg[g][c]  = 1'($urandom_range(0, 1));
        dword_cfg[g][c] = 9'($urandom);
      end
      h = $urandom_range(2, 4);
      l = $urandom_range(2, 4);
      oneshot(g, h, l);
    end

    // Extra start pulses while a request is pending and during RUN.
    for (int gg = 0; gg < 2; gg++) begin
      pi = 16'($urandom);
      base = fdone[gg];
      pulse_start(gg);
      pulse_start(gg);
      ticks(1, 3, 2);
      pulse_start(gg);
      ticks(2 * (8 + gg), 2, 3);
      ticks(2 * (8 + gg) + 2, 2, 3);
      chk($sformatf("req_frames%0d", gg), fdone[gg] - base, 1);
      chk($sformatf("req_busy%0d", gg), busy_w[gg], 0);
    end

    // Continuous: pi changed mid frame 1, en dropped mid frame 3.
    for (int gg = 0; gg < 2; gg++) begin
      pa = 16'($urandom);
      pb = ~pa;
      pi = pa;
      mode_v[gg] = 1'b1; en_v[gg] = 1'b1;
      base = fdone[gg]; bst = fstart[gg];
      ticks(1, 2, 3);
      ticks(8 + gg, 2, 3);
      pi = pb;
      ticks(8 + gg, 2, 3);
      ticks(2 * (8 + gg), 2, 3);
      ticks(8 + gg, 2, 3);
      en_v[gg] = 1'b0;
      ticks(8 + gg, 2, 3);
      ticks(4, 2, 3);
      chk($sformatf("cont_frames%0d", gg), fdone[gg] - base, 3);
      chk($sformatf("cont_f1_pi%0d", gg), pi_log[gg][(bst + 1) % 16], pa);
      chk($sformatf("cont_f2_pi%0d", gg), pi_log[gg][(bst + 2) % 16], pb);
      chk($sformatf("cont_f3_pi%0d", gg), pi_log[gg][(bst + 3) % 16], pb);
      chk($sformatf("cont_busy%0d", gg), busy_w[gg], 0);
      mode_v[gg] = 1'b0;
    end

    // Parity: clean loopback, then bit 3 of ch0 inverted on the return path.
    pi = {8'($urandom), 8'h07};
    loop_cfg[1][0] = 1'b1; loop_cfg[1][1] = 1'b1;
    oneshot(1, 2, 2);
    chk("par_perr_clean", perr_w[1], 2'b00);
    chk("par_po_clean", po_w[1][7:0], 8'h07);
    flip_cfg[1][0] = 9'h008;
    oneshot(1, 3, 2);
    chk("par_perr_flip", perr_w[1], 2'b01);
    chk("par_po_flip", po_w[1][7:0], 8'h0F);
    flip_cfg[1][0] = '0;
    loop_cfg[0][0] = 1'b1;
    flip_cfg[0][0] = 9'h008;
    oneshot(0, 2, 2);
    chk("nopar_perr_flip", perr_w[0], 2'b00);
    flip_cfg[0][0] = '0;

    // Minimum-width ticks, 16 back-to-back frames.
    pi = 16'($urandom);
    mode_v[0] = 1'b1; en_v[0] = 1'b1;
    base = fdone[0];
    ticks(256, 2, 2);
    en_v[0] = 1'b0;
    ticks(1, 2, 2);
    chk("minw_frames", fdone[0] - base, 16);
    ticks(4, 2, 2);
    chk("minw_frames_after", fdone[0] - base, 16);
    chk("minw_busy", busy_w[0], 0);
    mode_v[0] = 1'b0;

    // Asynchronous reset in the middle of a frame.
    pi = 16'($urandom);
    pulse_start(0);
    ticks(5, 2, 3);
    chk("midrst_busy_before", busy_w[0], 1);
    #3 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    base = fdone[0];
    ticks(2 * 8 + 4, 2, 3);
    chk("midrst_frames", fdone[0] - base, 0);
    chk("midrst_busy", busy_w[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
